// File: rtl/arb_mux_pkg.sv
//------------------------------------------------------------------------------
// Module   : arb_mux_pkg
// Brief    : Shared mode encodings and default sizing for the arb_mux_n block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_WIDTH  = 11;
    localparam int DEF_NUM_CH = 16;
    localparam int DEF_SEL_W  = 4;

endpackage

`default_nettype wire

// File: rtl/arb_mux_n_if.sv
//------------------------------------------------------------------------------
// Module   : arb_mux_n_if
// Brief    : Channel-side and output-side handshake bundle of arb_mux_n.
//            out_parity exists only when ARB_MUX_PARITY_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface arb_mux_n_if
    import arb_mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) ();

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;
`ifdef ARB_MUX_PARITY_EN
    logic                    out_parity;
`endif

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
`ifdef ARB_MUX_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
`ifdef ARB_MUX_PARITY_EN
        , output out_parity
`endif
    );

endinterface

`default_nettype wire

// File: rtl/arb_mux_n_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first requester at or after ptr,
//            wrapping to the lowest requester below ptr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_vld
);

    logic [NUM_CH-1:0] w_mask;
    logic [NUM_CH-1:0] w_hi_req;
    logic [SEL_W-1:0]  w_hi_idx;
    logic [SEL_W-1:0]  w_lo_idx;
    logic              w_hi_vld;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_mask
            assign w_mask[i] = (SEL_W'(i) >= ptr);
        end
    endgenerate

    assign w_hi_req = req & w_mask;

    // Descending scan so the lowest set index is the one that sticks.
    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        w_hi_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_hi_req[i]) begin
                w_hi_idx = SEL_W'(i);
                w_hi_vld = 1'b1;
            end
            if (req[i]) begin
                w_lo_idx = SEL_W'(i);
            end
        end
    end

    assign grant_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    assign grant_vld = |req;

endmodule

`default_nettype wire

// File: rtl/arb_mux_n.sv
//------------------------------------------------------------------------------
// Module   : arb_mux_n
// Brief    : N:1 registered selector, fixed-select or round-robin, with
//            valid/ready on both sides. ARB_MUX_PARITY_EN adds out_parity.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic        clk,
    input  logic        rst_n,
    arb_mux_n_if.slave  bus
);

    localparam logic [SEL_W:0]   c_NUM_CH  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_load_en;
    logic [SEL_W-1:0]  w_rr_idx;
    logic              w_rr_vld;
    logic              w_fix_vld;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic              w_gnt_vld;
    logic [NUM_CH-1:0] w_in_ready;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_sel_data;
    logic [SEL_W-1:0]  w_ptr_nxt;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req       (bus.in_valid),
        .ptr       (r_ptr),
        .grant_idx (w_rr_idx),
        .grant_vld (w_rr_vld)
    );

    assign w_load_en = !r_out_valid | bus.out_ready;
    // Extra MSB keeps the compare correct when NUM_CH == 2**SEL_W.
    assign w_fix_vld = ({1'b0, bus.sel} < c_NUM_CH);
    assign w_gnt_idx = (bus.mode == MODE_RR) ? w_rr_idx : bus.sel;
    assign w_gnt_vld = (bus.mode == MODE_RR) ? w_rr_vld : w_fix_vld;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ready
            assign w_in_ready[i] = w_load_en & w_gnt_vld & (w_gnt_idx == SEL_W'(i));
        end
    endgenerate

    assign w_xfer    = |(w_in_ready & bus.in_valid);
    assign w_ptr_nxt = (w_gnt_idx == c_LAST_CH) ? '0 : w_gnt_idx + SEL_W'(1);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ARB_MUX_PARITY_EN
    logic r_out_parity;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_out_valid  <= 1'b0;
            r_ptr        <= '0;
`ifdef ARB_MUX_PARITY_EN
            r_out_parity <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_out_data   <= w_sel_data;
            r_out_ch     <= w_gnt_idx;
            r_out_valid  <= 1'b1;
`ifdef ARB_MUX_PARITY_EN
            r_out_parity <= ^w_sel_data;
`endif
            if (bus.mode == MODE_RR) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (bus.out_ready & r_out_valid) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;
`ifdef ARB_MUX_PARITY_EN
    assign bus.out_parity = r_out_parity;
`endif

endmodule

`default_nettype wire
